// File: rtl/svc_rv_bpred_pkg.sv
// Shared branch-predictor types: BTB training payload and update-controller states.
package svc_rv_bpred_pkg;

   localparam int BPRED_XLEN = 32;

   typedef struct packed {
      logic [BPRED_XLEN-1:0] pc;
      logic [BPRED_XLEN-1:0] target;
      logic                  taken;
      logic                  is_return;
   } btb_upd_t;

   typedef enum logic [1:0] {
      IDLE,
      DRAIN,
      FLUSH
   } ctrl_state_t;

endpackage

// File: rtl/svc_rv_btb_upd_fifo.sv
// Small FIFO of BTB training updates with synchronous clear and a rewrite port
// for the newest entry.
module svc_rv_btb_upd_fifo
   import svc_rv_bpred_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  btb_upd_t                 push_data,
   input  logic                     pop,
   input  logic                     clear,
   input  logic                     tail_wr,
   input  btb_upd_t                 tail_data,
   output btb_upd_t                 head,
   output btb_upd_t                 tail,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   btb_upd_t      mem [DEPTH];
   logic [AW:0]   wr_ptr, rd_ptr;
   logic [AW-1:0] tail_idx;
   logic          do_push, do_pop;

   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign count    = wr_ptr - rd_ptr;
   assign tail_idx = wr_ptr[AW-1:0] - 1'b1;
   assign head     = mem[rd_ptr[AW-1:0]];
   assign tail     = mem[tail_idx];
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);

   // NOTE: storage has no reset; pointers alone define validity, and the top masks the
   // payload while the queue is empty, so clearing the array would only cost area.
   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr[AW-1:0]] <= push_data;
      else if (tail_wr && !empty)
         mem[tail_idx] <= tail_data;
   end

   // NOTE: sequential state is updated with non-blocking assignments only, so every
   // always_ff sees the pre-edge values regardless of evaluation order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/svc_rv_btb_upd_ctrl.sv
// Single write source for the BTB: drains queued training updates and runs the
// invalidate-all flush sequence. Define SVC_RV_BTB_UPD_COALESCE_EN to merge same-PC updates.
module svc_rv_btb_upd_ctrl
   import svc_rv_bpred_pkg::*;
#(
   parameter int XLEN        = BPRED_XLEN,
   parameter int DEPTH       = 4,
   parameter int BTB_ENTRIES = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           upd_valid,
   input  logic [XLEN-1:0]                upd_pc,
   input  logic [XLEN-1:0]                upd_target,
   input  logic                           upd_taken,
   input  logic                           upd_is_return,
   input  logic                           flush_req,
   output logic                           btb_wr_valid,
   input  logic                           btb_wr_ready,
   output logic                           btb_wr_inval,
   output logic [$clog2(BTB_ENTRIES)-1:0] btb_wr_idx,
   output logic [XLEN-1:0]                btb_wr_pc,
   output logic [XLEN-1:0]                btb_wr_target,
   output logic                           btb_wr_taken,
   output logic                           btb_wr_is_return,
   output logic                           flush_busy,
   output logic                           flush_done,
   output logic                           upd_dropped
);

   localparam int AW = $clog2(DEPTH);
   localparam int IW = $clog2(BTB_ENTRIES);

   ctrl_state_t   state, next_state;
   logic [IW-1:0] flush_idx;
   logic          flush_last;
   logic          flush_done_q, dropped_q;

   btb_upd_t      new_upd, q_head, q_tail;
   logic          q_full, q_empty;
   logic [AW:0]   q_count, next_count;
   logic          push, pop, clear, tail_wr, drop, coal_hit;

   assign new_upd = '{pc: upd_pc, target: upd_target, taken: upd_taken, is_return: upd_is_return};

   svc_rv_btb_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (new_upd),
      .pop       (pop),
      .clear     (clear),
      .tail_wr   (tail_wr),
      .tail_data (new_upd),
      .head      (q_head),
      .tail      (q_tail),
      .full      (q_full),
      .empty     (q_empty),
      .count     (q_count)
   );

   assign pop        = (state != FLUSH) && !q_empty && btb_wr_ready;
   assign flush_last = (flush_idx == IW'(BTB_ENTRIES - 1));

`ifdef SVC_RV_BTB_UPD_COALESCE_EN
   // The head leaving this cycle cannot be rewritten; otherwise the merge would be lost.
   assign coal_hit = !q_empty && (upd_pc == q_tail.pc) && !(pop && q_count == (AW+1)'(1));
`else
   logic unused_tail;
   assign unused_tail = ^q_tail;
   assign coal_hit    = 1'b0;
`endif

   // NOTE: every output of this block gets a default first, so no path infers a latch.
   always_comb begin
      next_state = state;
      push       = 1'b0;
      clear      = 1'b0;
      tail_wr    = 1'b0;
      drop       = 1'b0;
      next_count = q_count;
      case (state)
         IDLE, DRAIN: begin
            if (flush_req) begin
               clear      = 1'b1;
               drop       = upd_valid;
               next_state = FLUSH;
            end else begin
               if (upd_valid) begin
                  if (coal_hit)
                     tail_wr = 1'b1;
                  else if (!q_full || pop)
                     push = 1'b1;
                  else
                     drop = 1'b1;
               end
               next_count = q_count + (AW+1)'(push) - (AW+1)'(pop);
               next_state = (next_count != '0) ? DRAIN : IDLE;
            end
         end
         FLUSH: begin
            drop = upd_valid;
            if (btb_wr_ready && flush_last)
               next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      btb_wr_valid     = 1'b0;
      btb_wr_inval     = 1'b0;
      btb_wr_idx       = '0;
      btb_wr_pc        = '0;
      btb_wr_target    = '0;
      btb_wr_taken     = 1'b0;
      btb_wr_is_return = 1'b0;
      if (state == FLUSH) begin
         btb_wr_valid = 1'b1;
         btb_wr_inval = 1'b1;
         btb_wr_idx   = flush_idx;
      end else if (!q_empty) begin
         btb_wr_valid     = 1'b1;
         btb_wr_pc        = q_head.pc;
         btb_wr_target    = q_head.target;
         btb_wr_taken     = q_head.taken;
         btb_wr_is_return = q_head.is_return;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         flush_idx    <= '0;
         flush_done_q <= 1'b0;
         dropped_q    <= 1'b0;
      end else begin
         state        <= next_state;
         dropped_q    <= drop;
         flush_done_q <= (state == FLUSH) && btb_wr_ready && flush_last;
         if (state == FLUSH && btb_wr_ready)
            flush_idx <= flush_last ? '0 : flush_idx + 1'b1;
      end
   end

   assign flush_busy  = (state == FLUSH);
   assign flush_done  = flush_done_q;
   assign upd_dropped = dropped_q;

endmodule

// File: doc/svc_rv_btb_upd_ctrl.md
# svc_rv_btb_upd_ctrl

Sequences all writes into the BTB write port. Buffers training updates produced by the EX-stage branch analysis in a small queue and drains them into the BTB one per accepted handshake. On request, runs a flush sequence that invalidates every BTB entry, e.g. for fence.i or context change. Sits between the EX/MEM branch logic and the BTB, so the BTB has a single write source.

## Interface
- XLEN, 32, address/target width
- DEPTH, 4, update queue entries; power of two, ≥2
- BTB_ENTRIES, 16, BTB index count; power of two
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- upd_valid  in  1  training update from EX (one-cycle pulse per instruction)
- upd_pc  in  XLEN  PC of the branch/jump
- upd_target  in  XLEN  resolved target
- upd_taken  in  1  resolved outcome
- upd_is_return  in  1  return flag
- flush_req  in  1  start BTB invalidate sequence (level or pulse)
- btb_wr_valid  out  1  write request to BTB
- btb_wr_ready  in  1  BTB accepts write this cycle
- btb_wr_inval  out  1  1 = invalidate entry at btb_wr_idx; 0 = training write
- btb_wr_idx  out  $clog2(BTB_ENTRIES)  index for invalidate; 0 on training writes
- btb_wr_pc, btb_wr_target  out  XLEN  training payload; 0 when inval
- btb_wr_taken, btb_wr_is_return  out  1  training payload; 0 when inval
- flush_busy  out  1  flush sequence in progress
- flush_done  out  1  one-cycle pulse after the last invalidate is accepted
- upd_dropped  out  1  one-cycle pulse when an update was discarded

## Operation
- States: IDLE (queue empty), DRAIN (queue non-empty), FLUSH.
- IDLE/DRAIN: an update with upd_valid=1 is written at the tail. The head entry is presented on btb_wr_* with btb_wr_valid=1. The entry pops when btb_wr_valid && btb_wr_ready.
- Full queue with upd_valid=1 and no pop that cycle: the update is discarded and upd_dropped pulses. Updates are hints, so this loses no correctness. If a pop happens in the same cycle, the update is accepted.
- IDLE→DRAIN when an entry is present. DRAIN→IDLE when the last entry pops and none enters.
- flush_req=1 in IDLE/DRAIN: the queue is cleared, since its entries are stale. The block enters FLUSH next cycle with index counter 0, and any update in that cycle is discarded with upd_dropped.
- FLUSH:
  - btb_wr_valid=1, btb_wr_inval=1, btb_wr_idx=counter.
  - The counter increments on each accepted write.
  - On acceptance at index BTB_ENTRIES-1, the block goes to IDLE and flush_done pulses next cycle.
  - upd_valid during FLUSH is discarded with upd_dropped.
  - flush_req during FLUSH is ignored; the sequence does not restart.
- btb_wr_* payload must hold stable while btb_wr_valid=1 and btb_wr_ready=0.
- Pointers are $clog2(DEPTH) bits plus one wrap bit. Full and empty are derived from the wrap bit, and wrap-around at DEPTH-1→0 is natural.

## Timing
- Reset values:
  - state=IDLE, queue empty, counter 0.
  - All outputs 0.
- Update latency: upd_valid in cycle N, into an empty queue, gives btb_wr_valid=1 in cycle N+1 (registered storage, no bypass).
- Throughput: one write per cycle while btb_wr_ready=1.
- Flush: flush_req in cycle N gives flush_busy=1 and the first invalidate in N+1. With btb_wr_ready held at 1, the last invalidate is in N+BTB_ENTRIES and flush_done is in N+BTB_ENTRIES+1, with flush_busy=0.
- Reset asserted mid-flush or mid-drain: immediate return to reset values, with no pending writes.

## Configuration
- SVC_RV_BTB_UPD_COALESCE_EN defined: if upd_valid and upd_pc equals the PC of the newest queued entry, and that entry is not the head being accepted this cycle, the new update overwrites that entry's payload instead of enqueuing. No drop occurs even when the queue is full.
- Not defined: every update enqueues independently, per the full/drop rule above.

## Structure
- Shared package svc_rv_bpred_pkg holds:
  - btb_upd_t struct (pc, target, taken, is_return)
  - ctrl state enum (IDLE, DRAIN, FLUSH)
- One sub-module, svc_rv_btb_upd_fifo: parameterized DEPTH queue of btb_upd_t with push/pop/clear, full/empty, and a tail-entry rewrite port used by coalescing.
- The controller FSM, flush counter and output muxing live in the top module.

## Test plan
- Reset then single update: pc=0x100, target=0x180, taken=1 in cycle 1 → btb_wr_valid in cycle 2 with the same payload, inval=0; queue empty after the handshake.
- Backpressure: btb_wr_ready=0; 5 updates with DEPTH=4 → the 5th gives an upd_dropped pulse. Raise ready → exactly 4 writes drain in FIFO order, with payload stable during the stall.
- Full queue plus simultaneous pop and push → the update is accepted, no drop, and order is preserved.
- Flush with 2 entries queued:
  - flush_req pulse → queue discarded; invalidates for idx 0..15 follow.
  - With ready toggling 1/0, each index is issued exactly once.
  - flush_done pulses once, then IDLE.
- Update and second flush_req during FLUSH → upd_dropped pulses, the sequence is not restarted, and the total invalidate count is 16.
- With SVC_RV_BTB_UPD_COALESCE_EN, ready=0: two updates to pc=0x200 (taken=0, then taken=1) → one queued entry; the drained write has taken=1. Without the macro → two writes.
- Assert rst while in FLUSH at idx 7 → all outputs 0 immediately. No further invalidates until a new flush_req, which restarts at idx 0.
